alu_pipe_core: RTL and testbench

//  Parametrised next-generation ALU. Collects operands A/B (together or split) under a

---
 rtl/alu_pipe_pkg.sv | 53 +++++
 rtl/alu_pipe_core_if.sv | 32 +++
 rtl/alu_exec_unit.sv | 118 +++++++++++
 rtl/alu_pipe_core.sv | 152 +++++++++++++++
 tb/tb_alu_pipe_core.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pipe_pkg.sv
// Shared types for the pipelined ALU: command encodings, FSM states and result flags.
package alu_pipe_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_A,
    WAIT_B,
    EXEC,
    MUL2
  } state_t;

  typedef enum logic [3:0] {
    A_ADD     = 4'd0,
    A_SUB     = 4'd1,
    A_ADD_CIN = 4'd2,
    A_SUB_CIN = 4'd3,
    A_INC_A   = 4'd4,
    A_DEC_A   = 4'd5,
    A_INC_B   = 4'd6,
    A_DEC_B   = 4'd7,
    A_CMP     = 4'd8,
    A_MUL_INC = 4'd9,
    A_MUL_SHL = 4'd10
  } arith_cmd_e;

  typedef enum logic [3:0] {
    L_AND    = 4'd0,
    L_NAND   = 4'd1,
    L_OR     = 4'd2,
    L_NOR    = 4'd3,
    L_XOR    = 4'd4,
    L_XNOR   = 4'd5,
    L_NOT_A  = 4'd6,
    L_NOT_B  = 4'd7,
    L_SHR1_A = 4'd8,
    L_SHL1_A = 4'd9,
    L_SHR1_B = 4'd10,
    L_SHL1_B = 4'd11,
    L_ROL    = 4'd12,
    L_ROR    = 4'd13
  } logic_cmd_e;

  // Result width depends on DW, so the flags travel as a struct beside the result bus.
  typedef struct packed {
    logic cout;
    logic oflow;
    logic g;
    logic e;
    logic l;
    logic err;
  } alu_flags_t;

endpackage

// File: rtl/alu_pipe_core_if.sv
// Operand/command source and result consumer bus of alu_pipe_core.
interface alu_pipe_core_if #(
  parameter int DW = 8,
  parameter int CW = 4
) ();
  logic            CE;
  logic            MODE;
  logic [CW-1:0]   CMD;
  logic [1:0]      INP_VALID;
  logic [DW-1:0]   OPA;
  logic [DW-1:0]   OPB;
  logic            CIN;
  logic [2*DW-1:0] RES;
  logic            COUT;
  logic            OFLOW;
  logic            G;
  logic            E;
  logic            L;
  logic            ERR;
  logic            OUT_VALID;
  logic            BUSY;

  modport master (
    output CE, MODE, CMD, INP_VALID, OPA, OPB, CIN,
    input  RES, COUT, OFLOW, G, E, L, ERR, OUT_VALID, BUSY
  );

  modport slave (
    input  CE, MODE, CMD, INP_VALID, OPA, OPB, CIN,
    output RES, COUT, OFLOW, G, E, L, ERR, OUT_VALID, BUSY
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Combinational ALU datapath. Multiplies are returned on mul_p as the stage-1 product
// for the parent to register; res/flags cover every single-cycle command.
module alu_exec_unit
  import alu_pipe_pkg::*;
#(
  parameter int DW = 8,
  parameter int CW = 4
) (
  input  logic            mode,
  input  logic [CW-1:0]   cmd,
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  input  logic            cin,
  output logic [2*DW-1:0] res,
  output alu_flags_t      flags,
  output logic            is_mul,
  output logic [2*DW-1:0] mul_p
);
  localparam int RW  = 2 * DW;
  localparam int SHW = $clog2(DW);
  localparam logic [DW:0] ONE_X = (DW+1)'(1);

  logic [DW:0]    a_x, b_x, cin_x;
  logic [DW:0]    add_r, sub_r, fa, fb;
  logic [DW-1:0]  lres;
  logic [RW-1:0]  rot;
  logic [SHW-1:0] rot_amt;
  logic           rot_bad, cmd_hi, is_add, is_sub, is_logic;

  assign a_x     = {1'b0, a};
  assign b_x     = {1'b0, b};
  assign cin_x   = {{DW{1'b0}}, cin};
  assign rot_amt = b[SHW-1:0];
  assign rot_bad = |(b >> SHW);
  assign cmd_hi  = |(cmd >> 4);

  always_comb begin
    res      = '0;
    flags    = '0;
    is_mul   = 1'b0;
    mul_p    = '0;
    add_r    = '0;
    sub_r    = '0;
    fa       = '0;
    fb       = '0;
    lres     = '0;
    rot      = '0;
    is_add   = 1'b0;
    is_sub   = 1'b0;
    is_logic = 1'b0;

    if (cmd_hi) begin
      flags.err = 1'b1;
    end else if (mode) begin
      // Subtractions run one bit wide so the top bit of the difference is the borrow.
      unique case (arith_cmd_e'(cmd[3:0]))
        A_ADD:     begin add_r = a_x + b_x;          is_add = 1'b1; end
        A_ADD_CIN: begin add_r = a_x + b_x + cin_x;  is_add = 1'b1; end
        A_INC_A:   begin add_r = a_x + ONE_X;        is_add = 1'b1; end
        A_INC_B:   begin add_r = b_x + ONE_X;        is_add = 1'b1; end
        A_SUB:     begin sub_r = a_x - b_x;          is_sub = 1'b1; end
        A_SUB_CIN: begin sub_r = a_x - b_x - cin_x;  is_sub = 1'b1; end
        A_DEC_A:   begin sub_r = a_x - ONE_X;        is_sub = 1'b1; end
        A_DEC_B:   begin sub_r = b_x - ONE_X;        is_sub = 1'b1; end
        A_CMP: begin
          flags.g = (a > b);
          flags.e = (a == b);
          flags.l = (a < b);
        end
        A_MUL_INC: begin fa = a_x + ONE_X; fb = b_x + ONE_X; is_mul = 1'b1; end
        A_MUL_SHL: begin fa = {a, 1'b0};   fb = b_x;         is_mul = 1'b1; end
        default:   flags.err = 1'b1;
      endcase
    end else begin
      is_logic = 1'b1;
      unique case (logic_cmd_e'(cmd[3:0]))
        L_AND:    lres = a & b;
        L_NAND:   lres = ~(a & b);
        L_OR:     lres = a | b;
        L_NOR:    lres = ~(a | b);
        L_XOR:    lres = a ^ b;
        L_XNOR:   lres = ~(a ^ b);
        L_NOT_A:  lres = ~a;
        L_NOT_B:  lres = ~b;
        L_SHR1_A: lres = a >> 1;
        L_SHL1_A: lres = a << 1;
        L_SHR1_B: lres = b >> 1;
        L_SHL1_B: lres = b << 1;
        L_ROL: begin
          rot       = {a, a} << rot_amt;
          lres      = rot[RW-1:DW];
          flags.err = rot_bad;
        end
        L_ROR: begin
          rot       = {a, a} >> rot_amt;
          lres      = rot[DW-1:0];
          flags.err = rot_bad;
        end
        default: begin
          is_logic  = 1'b0;
          flags.err = 1'b1;
        end
      endcase
    end

    if (is_add) begin
      res        = RW'(add_r);
      flags.cout = add_r[DW];
    end
    if (is_sub) begin
      res         = RW'(sub_r[DW-1:0]);
      flags.oflow = sub_r[DW];
    end
    if (is_logic) res = {{DW{1'b0}}, lres};
    if (is_mul)   mul_p = RW'(fa) * RW'(fb);
  end

endmodule

// File: rtl/alu_pipe_core.sv
// Pipelined ALU top: operand-collection FSM with timeout, operand/command registers,
// multiply second stage and registered result outputs with a one-cycle OUT_VALID pulse.
module alu_pipe_core
  import alu_pipe_pkg::*;
#(
  parameter int DW      = 8,
  parameter int CW      = 4,
  parameter int TIMEOUT = 16
) (
  input  logic            CLK,
  input  logic            RST,
  alu_pipe_core_if.slave  bus
);
  localparam int RW   = 2 * DW;
  localparam int CNTW = $clog2(TIMEOUT + 1);
  localparam logic [CNTW-1:0] TO_LAST = CNTW'(TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [DW-1:0]   a_q, a_d, b_q, b_d;
  logic [CW-1:0]   cmd_q, cmd_d;
  logic            mode_q, mode_d, cin_q, cin_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [RW-1:0]   mul_q, mul_d, res_q, res_d;
  alu_flags_t      flags_q, flags_d;
  logic            ov_q, ov_d;

  logic            va, vb, cap;
  logic [RW-1:0]   ex_res, ex_mul;
  alu_flags_t      ex_flags;
  logic            ex_is_mul;

  assign va = bus.INP_VALID[0];
  assign vb = bus.INP_VALID[1];

  alu_exec_unit #(.DW(DW), .CW(CW)) u_exec (
    .mode   (mode_q),
    .cmd    (cmd_q),
    .a      (a_q),
    .b      (b_q),
    .cin    (cin_q),
    .res    (ex_res),
    .flags  (ex_flags),
    .is_mul (ex_is_mul),
    .mul_p  (ex_mul)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cmd_d   = cmd_q;
    mode_d  = mode_q;
    cin_d   = cin_q;
    cnt_d   = cnt_q;
    mul_d   = mul_q;
    res_d   = res_q;
    flags_d = flags_q;
    ov_d    = 1'b0;
    cap     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (va || vb) begin
          cap     = 1'b1;
          state_d = (va && vb) ? EXEC : (va ? WAIT_B : WAIT_A);
        end
      end
      // Any capture (missing, repeated or both operands) restarts the idle count.
      WAIT_A, WAIT_B: begin
        if (va || vb) begin
          cap = 1'b1;
          if ((state_q == WAIT_A && va) || (state_q == WAIT_B && vb)) state_d = EXEC;
        end else if (cnt_q == TO_LAST) begin
          state_d   = IDLE;
          res_d     = '0;
          flags_d   = '0;
          flags_d.err = 1'b1;
          ov_d      = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      EXEC: begin
        if (ex_is_mul) begin
          mul_d   = ex_mul;
          state_d = MUL2;
        end else begin
          res_d   = ex_res;
          flags_d = ex_flags;
          ov_d    = 1'b1;
          state_d = IDLE;
        end
      end
      MUL2: begin
        res_d   = mul_q;
        flags_d = '0;
        ov_d    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (cap) begin
      cmd_d  = bus.CMD;
      mode_d = bus.MODE;
      cin_d  = bus.CIN;
      cnt_d  = '0;
      if (va) a_d = bus.OPA;
      if (vb) b_d = bus.OPB;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cmd_q   <= '0;
      mode_q  <= 1'b0;
      cin_q   <= 1'b0;
      cnt_q   <= '0;
      mul_q   <= '0;
      res_q   <= '0;
      flags_q <= '0;
      ov_q    <= 1'b0;
    end else if (bus.CE) begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cmd_q   <= cmd_d;
      mode_q  <= mode_d;
      cin_q   <= cin_d;
      cnt_q   <= cnt_d;
      mul_q   <= mul_d;
      res_q   <= res_d;
      flags_q <= flags_d;
      ov_q    <= ov_d;
    end
  end

  assign bus.RES       = res_q;
  assign bus.COUT      = flags_q.cout;
  assign bus.OFLOW     = flags_q.oflow;
  assign bus.G         = flags_q.g;
  assign bus.E         = flags_q.e;
  assign bus.L         = flags_q.l;
  assign bus.ERR       = flags_q.err;
  assign bus.OUT_VALID = ov_q;
  assign bus.BUSY      = (state_q == EXEC) || (state_q == MUL2);

endmodule

// File: tb/tb_alu_pipe_core.sv
// Bench for alu_pipe_core (DW=8): directed scenarios then random operations, all checked
// against an integer-arithmetic reference of the command table.
module tb_alu_pipe_core;
  localparam int DW      = 8;
  localparam int CW      = 4;
  localparam int TIMEOUT = 16;

  typedef struct packed {
    logic [15:0] res;
    logic        cout;
    logic        oflow;
    logic        g;
    logic        e;
    logic        l;
    logic        err;
  } exp_t;

  logic CLK = 1'b0;
  logic RST;
  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t last;

  always #5 CLK = ~CLK;

  alu_pipe_core_if #(.DW(DW), .CW(CW)) bus ();

  alu_pipe_core #(.DW(DW), .CW(CW), .TIMEOUT(TIMEOUT)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  function automatic bit is_mul_op(bit mode, int cmd);
    return mode && (cmd == 9 || cmd == 10);
  endfunction

  function automatic exp_t model(bit mode, int cmd, int a, int b, bit cin);
    exp_t r = '0;
    int   t;
    int   s = b % 8;
    if (mode) begin
      case (cmd)
        0:  begin t = a + b;       r.res = 16'(t); r.cout = (t > 255); end
        1:  begin t = a - b;       r.res = 16'(t & 255); r.oflow = (t < 0); end
        2:  begin t = a + b + cin; r.res = 16'(t); r.cout = (t > 255); end
        3:  begin t = a - b - cin; r.res = 16'(t & 255); r.oflow = (t < 0); end
        4:  begin t = a + 1;       r.res = 16'(t); r.cout = (t > 255); end
        5:  begin t = a - 1;       r.res = 16'(t & 255); r.oflow = (t < 0); end
        6:  begin t = b + 1;       r.res = 16'(t); r.cout = (t > 255); end
        7:  begin t = b - 1;       r.res = 16'(t & 255); r.oflow = (t < 0); end
        8:  begin r.g = (a > b); r.e = (a == b); r.l = (a < b); end
        9:  r.res = 16'((a + 1) * (b + 1));
        10: r.res = 16'(2 * a * b);
        default: r.err = 1'b1;
      endcase
    end else begin
      case (cmd)
        0:  r.res = 16'(a & b);
        1:  r.res = 16'(~(a & b) & 255);
        2:  r.res = 16'(a | b);
        3:  r.res = 16'(~(a | b) & 255);
        4:  r.res = 16'(a ^ b);
        5:  r.res = 16'(~(a ^ b) & 255);
        6:  r.res = 16'(~a & 255);
        7:  r.res = 16'(~b & 255);
        8:  r.res = 16'(a / 2);
        9:  r.res = 16'((a * 2) & 255);
        10: r.res = 16'(b / 2);
        11: r.res = 16'((b * 2) & 255);
        12: begin r.res = 16'(((a << s) | (a >> (8 - s))) & 255); r.err = (b >= 8); end
        13: begin r.res = 16'(((a >> s) | (a << (8 - s))) & 255); r.err = (b >= 8); end
        default: r.err = 1'b1;
      endcase
    end
    return r;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_st(string tag, logic [1:0] busy_ov);
    chk(tag, 64'({bus.BUSY, bus.OUT_VALID}), 64'(busy_ov));
  endtask

  task automatic chk_out(string tag, exp_t e);
    chk(tag, 64'({bus.RES, bus.COUT, bus.OFLOW, bus.G, bus.E, bus.L, bus.ERR}), 64'(e));
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(logic [1:0] v, bit mode, int cmd, int a, int b, bit cin);
    bus.INP_VALID = v;
    bus.MODE      = mode;
    bus.CMD       = 4'(cmd);
    bus.OPA       = 8'(a);
    bus.OPB       = 8'(b);
    bus.CIN       = cin;
  endtask

  task automatic idle_in();
    bus.INP_VALID = 2'b00;
  endtask

  // Called just after the edge that captured the final operand.
  task automatic finish_op(string tag, exp_t e, int lat);
    for (int i = 0; i < lat; i++) begin
      chk_st({tag, "_busy"}, 2'b10);
      step();
    end
    chk_st({tag, "_pulse"}, 2'b01);
    chk_out(tag, e);
    last = e;
    idle_in();
    step();
    chk_st({tag, "_pulse_end"}, 2'b00);
  endtask

  task automatic do_op(string tag, bit mode, int cmd, int a, int b, bit cin, bit noise);
    exp_t e = model(mode, cmd, a, b, cin);
    drive(2'b11, mode, cmd, a, b, cin);
    step();
    if (noise) drive(2'b11, ~mode, 8, b, a, ~cin);
    else       idle_in();
    finish_op(tag, e, is_mul_op(mode, cmd) ? 2 : 1);
  endtask

  // First capture carries a junk CMD/CIN; the later capture's values must win.
  task automatic split_op(string tag, bit mode, int cmd, int a, int b, bit cin,
                          bit a_first, int idle);
    exp_t e = model(mode, cmd, a, b, cin);
    drive(a_first ? 2'b01 : 2'b10, mode, int'($urandom_range(0, 15)), a, b,
          1'($urandom_range(0, 1)));
    step();
    idle_in();
    chk_st({tag, "_wait"}, 2'b00);
    repeat (idle) step();
    drive(a_first ? 2'b10 : 2'b01, mode, cmd, a, b, cin);
    step();
    idle_in();
    finish_op(tag, e, is_mul_op(mode, cmd) ? 2 : 1);
  endtask

  initial begin
    exp_t e;
    exp_t to_e;
    RST    = 1'b1;
    bus.CE = 1'b1;
    drive(2'b00, 1'b0, 0, 0, 0, 1'b0);
    repeat (3) step();
    chk("reset", 64'({bus.RES, bus.COUT, bus.OFLOW, bus.G, bus.E, bus.L, bus.ERR,
                      bus.OUT_VALID, bus.BUSY}), 64'(0));
    RST  = 1'b0;
    last = '0;

    do_op("add_carry", 1'b1, 0, 8'hFF, 8'h01, 1'b0, 1'b0);
    do_op("mul_inc_noise", 1'b1, 9, 3, 4, 1'b0, 1'b1);
    step();
    chk_st("mul_noise_ignored", 2'b00);

    split_op("sub_split", 1'b1, 1, 10, 3, 1'b0, 1'b1, 5);
    split_op("sub_borrow", 1'b1, 1, 10, 12, 1'b0, 1'b1, 5);

    to_e     = '0;
    to_e.err = 1'b1;
    drive(2'b01, 1'b1, 0, 8'h55, 0, 1'b0);
    step();
    idle_in();
    repeat (TIMEOUT - 1) step();
    chk_st("timeout_early", 2'b00);
    step();
    chk_st("timeout_pulse", 2'b01);
    chk_out("timeout_out", to_e);
    last = to_e;
    step();
    chk_st("timeout_idle", 2'b00);
    split_op("after_timeout", 1'b1, 0, 8'h20, 8'h30, 1'b0, 1'b0, 3);

    drive(2'b01, 1'b1, 0, 7, 0, 1'b0);
    step();
    idle_in();
    repeat (10) step();
    drive(2'b01, 1'b1, 0, 9, 0, 1'b0);
    step();
    idle_in();
    repeat (10) step();
    chk_st("resend_no_timeout", 2'b00);
    drive(2'b10, 1'b1, 0, 9, 2, 1'b0);
    step();
    idle_in();
    finish_op("resend_add", model(1'b1, 0, 9, 2, 1'b0), 1);

    do_op("rol_ok", 1'b0, 12, 8'h81, 8'h01, 1'b0, 1'b0);
    do_op("rol_bad", 1'b0, 12, 8'h81, 8'h10, 1'b0, 1'b0);
    do_op("sub_cin", 1'b1, 3, 5, 5, 1'b1, 1'b0);
    do_op("dec_zero", 1'b1, 5, 0, 9, 1'b0, 1'b0);

    drive(2'b01, 1'b1, 1, 8'h40, 0, 1'b0);
    step();
    idle_in();
    repeat (3) step();
    bus.CE = 1'b0;
    drive(2'b10, 1'b1, 4, 8'h40, 8'h11, 1'b1);
    repeat (20) step();
    chk_out("ce_hold_out", last);
    chk_st("ce_hold_st", 2'b00);
    idle_in();
    bus.CE = 1'b1;
    repeat (TIMEOUT - 4) step();
    chk_st("ce_cnt_frozen", 2'b00);
    drive(2'b10, 1'b1, 1, 8'h40, 8'h05, 1'b0);
    step();
    idle_in();
    finish_op("ce_resume", model(1'b1, 1, 8'h40, 8'h05, 1'b0), 1);

    drive(2'b11, 1'b1, 10, 5, 7, 1'b0);
    step();
    idle_in();
    step();
    chk_st("mul2_reached", 2'b10);
    RST = 1'b1;
    step();
    chk("rst_mul2", 64'({bus.RES, bus.COUT, bus.OFLOW, bus.G, bus.E, bus.L, bus.ERR,
                         bus.OUT_VALID, bus.BUSY}), 64'(0));
    RST = 1'b0;
    step();
    chk_st("rst_no_pulse", 2'b00);
    last = '0;

    for (int k = 0; k < 40; k++) begin
      bit mode = 1'($urandom_range(0, 1));
      int cmd  = int'($urandom_range(0, 15));
      int a    = int'($urandom_range(0, 255));
      int b    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7))
                                             : int'($urandom_range(0, 255));
      bit cin  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 0)
        do_op("rand_pair", mode, cmd, a, b, cin, 1'($urandom_range(0, 1)));
      else
        split_op("rand_split", mode, cmd, a, b, cin, 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 6)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
